// File: rtl/uart_cmd_engine.sv
// PIO-controlled 8N1 UART: command-word edge detection, independent TX and RX engines,
// and sticky receive status flags cleared by command.
module uart_cmd_engine #(
    parameter int CLKS_PER_BIT = 434
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic [2:0] cmd_i,
    input  logic [7:0] tx_data_i,
    input  logic       uart_rx_i,
    output logic [2:0] status_o,
    output logic [7:0] rx_data_o,
    output logic       uart_tx_o
);

    localparam int CW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_START = 2'd1,
        ST_DATA  = 2'd2,
        ST_STOP  = 2'd3
    } uart_state_e;

    logic [2:0]  cmd_prev_r;
    logic [1:0]  rx_sync_r;
    logic        tx_start_s;
    logic        clear_s;
    logic        rx_enable_s;
    logic        rx_line_s;

    uart_state_e tx_state_r, tx_state_n;
    logic [CW-1:0] tx_cnt_r, tx_cnt_n;
    logic [2:0]  tx_bit_r, tx_bit_n;
    logic [7:0]  tx_shreg_r, tx_shreg_n;
    logic        tx_line_r, tx_line_n;
    logic        tx_busy_r, tx_busy_n;

    uart_state_e rx_state_r, rx_state_n;
    logic [CW-1:0] rx_cnt_r, rx_cnt_n;
    logic [2:0]  rx_bit_r, rx_bit_n;
    logic [7:0]  rx_shreg_r, rx_shreg_n;
    logic [7:0]  rx_data_r, rx_data_n;
    logic        rx_valid_r, rx_valid_n;
    logic        rx_error_r, rx_error_n;
    logic        set_valid_s;
    logic        set_error_s;

    // Previous command bits for edge detection; cleared by reset so a held bit reads as an edge
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cmd_prev_r <= 3'b000;
        end else begin
            cmd_prev_r <= cmd_i;
        end
    end

    // Two-flop synchronizer for the asynchronous serial input, idle high
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_sync_r <= 2'b11;
        end else begin
            rx_sync_r <= {rx_sync_r[0], uart_rx_i};
        end
    end

    assign tx_start_s  = cmd_i[0] & ~cmd_prev_r[0];
    assign clear_s     = cmd_i[2] & ~cmd_prev_r[2];
    assign rx_enable_s = cmd_i[1];
    assign rx_line_s   = rx_sync_r[1];

    // TX next-state logic; line and busy are computed from the next state so they register cleanly
    always_comb begin
        tx_state_n = tx_state_r;
        tx_cnt_n   = tx_cnt_r;
        tx_bit_n   = tx_bit_r;
        tx_shreg_n = tx_shreg_r;
        case (tx_state_r)
            ST_IDLE: begin
                tx_cnt_n = {CW{1'b0}};
                if (tx_start_s) begin
                    tx_state_n = ST_START;
                    tx_shreg_n = tx_data_i;
                    tx_bit_n   = 3'd0;
                end else begin
                    tx_state_n = ST_IDLE;
                end
            end
            ST_START: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_n = ST_DATA;
                    tx_cnt_n   = {CW{1'b0}};
                end else begin
                    tx_cnt_n = tx_cnt_r + CW'(1);
                end
            end
            ST_DATA: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_cnt_n = {CW{1'b0}};
                    if (tx_bit_r == 3'd7) begin
                        tx_state_n = ST_STOP;
                    end else begin
                        tx_bit_n   = tx_bit_r + 3'd1;
                        tx_shreg_n = {1'b0, tx_shreg_r[7:1]};
                    end
                end else begin
                    tx_cnt_n = tx_cnt_r + CW'(1);
                end
            end
            ST_STOP: begin
                if (tx_cnt_r == BIT_LAST) begin
                    tx_state_n = ST_IDLE;
                    tx_cnt_n   = {CW{1'b0}};
                end else begin
                    tx_cnt_n = tx_cnt_r + CW'(1);
                end
            end
            default: begin
                tx_state_n = ST_IDLE;
                tx_cnt_n   = {CW{1'b0}};
            end
        endcase

        case (tx_state_n)
            ST_START: tx_line_n = 1'b0;
            ST_DATA:  tx_line_n = tx_shreg_n[0];
            default:  tx_line_n = 1'b1;
        endcase
        tx_busy_n = (tx_state_n != ST_IDLE);
    end

    // TX state and registered serial output
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            tx_state_r <= ST_IDLE;
            tx_cnt_r   <= {CW{1'b0}};
            tx_bit_r   <= 3'd0;
            tx_shreg_r <= 8'h00;
            tx_line_r  <= 1'b1;
            tx_busy_r  <= 1'b0;
        end else begin
            tx_state_r <= tx_state_n;
            tx_cnt_r   <= tx_cnt_n;
            tx_bit_r   <= tx_bit_n;
            tx_shreg_r <= tx_shreg_n;
            tx_line_r  <= tx_line_n;
            tx_busy_r  <= tx_busy_n;
        end
    end

    // RX next-state logic; dropping rx_enable aborts without touching data or flags
    always_comb begin
        rx_state_n  = rx_state_r;
        rx_cnt_n    = rx_cnt_r;
        rx_bit_n    = rx_bit_r;
        rx_shreg_n  = rx_shreg_r;
        rx_data_n   = rx_data_r;
        set_valid_s = 1'b0;
        set_error_s = 1'b0;
        if (!rx_enable_s && (rx_state_r != ST_IDLE)) begin
            rx_state_n = ST_IDLE;
            rx_cnt_n   = {CW{1'b0}};
        end else begin
            case (rx_state_r)
                ST_IDLE: begin
                    rx_cnt_n = {CW{1'b0}};
                    if (rx_enable_s && !rx_line_s) begin
                        rx_state_n = ST_START;
                        rx_bit_n   = 3'd0;
                    end else begin
                        rx_state_n = ST_IDLE;
                    end
                end
                ST_START: begin
                    if (rx_cnt_r == HALF_LAST) begin
                        rx_cnt_n   = {CW{1'b0}};
                        rx_state_n = rx_line_s ? ST_IDLE : ST_DATA;
                    end else begin
                        rx_cnt_n = rx_cnt_r + CW'(1);
                    end
                end
                ST_DATA: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_n   = {CW{1'b0}};
                        rx_shreg_n = {rx_line_s, rx_shreg_r[7:1]};
                        if (rx_bit_r == 3'd7) begin
                            rx_state_n = ST_STOP;
                        end else begin
                            rx_bit_n = rx_bit_r + 3'd1;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt_r + CW'(1);
                    end
                end
                ST_STOP: begin
                    if (rx_cnt_r == BIT_LAST) begin
                        rx_cnt_n   = {CW{1'b0}};
                        rx_state_n = ST_IDLE;
                        if (rx_line_s) begin
                            rx_data_n   = rx_shreg_r;
                            set_valid_s = 1'b1;
                        end else begin
                            set_error_s = 1'b1;
                        end
                    end else begin
                        rx_cnt_n = rx_cnt_r + CW'(1);
                    end
                end
                default: begin
                    rx_state_n = ST_IDLE;
                    rx_cnt_n   = {CW{1'b0}};
                end
            endcase
        end
        // A set in the same cycle as a clear takes priority
        rx_valid_n = set_valid_s | (rx_valid_r & ~clear_s);
        rx_error_n = set_error_s | (rx_error_r & ~clear_s);
    end

    // RX state, received byte and sticky flags
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rx_state_r <= ST_IDLE;
            rx_cnt_r   <= {CW{1'b0}};
            rx_bit_r   <= 3'd0;
            rx_shreg_r <= 8'h00;
            rx_data_r  <= 8'h00;
            rx_valid_r <= 1'b0;
            rx_error_r <= 1'b0;
        end else begin
            rx_state_r <= rx_state_n;
            rx_cnt_r   <= rx_cnt_n;
            rx_bit_r   <= rx_bit_n;
            rx_shreg_r <= rx_shreg_n;
            rx_data_r  <= rx_data_n;
            rx_valid_r <= rx_valid_n;
            rx_error_r <= rx_error_n;
        end
    end

    assign uart_tx_o = tx_line_r;
    assign rx_data_o = rx_data_r;
    assign status_o  = {rx_error_r, rx_valid_r, tx_busy_r};

endmodule

// File: tb/tb_uart_cmd_engine.sv
// Directed self-checking bench for uart_cmd_engine at CLKS_PER_BIT=8: table-driven RX frames
// plus hand-written TX, loopback, glitch, abort, flag-priority and reset sequences.
module tb_uart_cmd_engine;

    logic       clk;
    logic       reset_n;
    logic [2:0] cmd;
    logic [7:0] tx_data;
    logic       bench_rx;
    logic       loop_en;
    logic       uart_rx;
    logic [2:0] status;
    logic [7:0] rx_data;
    logic       uart_tx;

    int n_cmp;
    int n_fail;

    typedef struct {
        logic [7:0] data;
        logic       stop_bit;
        logic       clr_before;
        logic [7:0] exp_data;
        logic [2:0] exp_status;
    } rx_vec_t;

    rx_vec_t    vecs [7];
    logic [9:0] exp_seq;

    assign uart_rx = loop_en ? uart_tx : bench_rx;

    uart_cmd_engine #(.CLKS_PER_BIT(8)) dut (
        .clk       (clk),
        .reset_n   (reset_n),
        .cmd_i     (cmd),
        .tx_data_i (tx_data),
        .uart_rx_i (uart_rx),
        .status_o  (status),
        .rx_data_o (rx_data),
        .uart_tx_o (uart_tx)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    task automatic wait_neg(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic pulse_clear();
        @(negedge clk);
        cmd[2] = 1'b1;
        @(negedge clk);
        cmd[2] = 1'b0;
        @(negedge clk);
    endtask

    // Drives one frame on bench_rx, 8 cycles per bit; optional clear pulse and rx_enable drop at given cycle
    task automatic send_frame(input logic [7:0] d, input logic stop, input int clr_at, input int drop_at);
        logic [9:0] fr;
        fr = {stop, d, 1'b0};
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            bench_rx = fr[k / 8];
            if (k == clr_at) cmd[2] = 1'b1;
            if (k == clr_at + 1) cmd[2] = 1'b0;
            if (k == drop_at) cmd[1] = 1'b0;
        end
        @(negedge clk);
        bench_rx = 1'b1;
        cmd[2]   = 1'b0;
        wait_neg(16);
    endtask

    initial begin
        n_cmp    = 0;
        n_fail   = 0;
        reset_n  = 1'b0;
        cmd      = 3'b010;
        tx_data  = 8'h00;
        bench_rx = 1'b1;
        loop_en  = 1'b0;
        exp_seq  = 10'b1101001010;

        vecs[0] = '{8'h81, 1'b0, 1'b0, 8'h3C, 3'b100};
        vecs[1] = '{8'h5A, 1'b1, 1'b0, 8'h5A, 3'b110};
        vecs[2] = '{8'h81, 1'b0, 1'b0, 8'h5A, 3'b110};
        vecs[3] = '{8'hFF, 1'b1, 1'b1, 8'hFF, 3'b010};
        vecs[4] = '{8'h00, 1'b1, 1'b0, 8'h00, 3'b010};
        vecs[5] = '{8'hC3, 1'b0, 1'b1, 8'h00, 3'b100};
        vecs[6] = '{8'h96, 1'b1, 1'b1, 8'h96, 3'b010};

        wait_neg(2);
        check("reset_tx", uart_tx, 1'b1);
        check("reset_status", status, 3'b000);
        check("reset_rx_data", rx_data, 8'h00);
        reset_n = 1'b1;
        wait_neg(3);
        check("idle_tx", uart_tx, 1'b1);
        check("idle_status", status, 3'b000);

        // TX 0xA5 with a second start edge and data change mid-frame
        tx_data = 8'hA5;
        cmd[0]  = 1'b1;
        for (int k = 0; k < 80; k++) begin
            @(negedge clk);
            check($sformatf("tx_bit_k%0d", k), uart_tx, exp_seq[k / 8]);
            check($sformatf("tx_busy_k%0d", k), status[0], 1'b1);
            if (k == 0) cmd[0] = 1'b0;
            if (k == 20) begin
                tx_data = 8'h00;
                cmd[0]  = 1'b1;
            end
            if (k == 21) cmd[0] = 1'b0;
        end
        @(negedge clk);
        check("tx_done_busy", status[0], 1'b0);
        check("tx_done_line", uart_tx, 1'b1);
        wait_neg(4);
        check("tx_no_requeue", status[0], 1'b0);

        // Loopback 0x3C then clear
        loop_en = 1'b1;
        tx_data = 8'h3C;
        cmd[0]  = 1'b1;
        @(negedge clk);
        cmd[0] = 1'b0;
        wait_neg(100);
        check("loop_rx_data", rx_data, 8'h3C);
        check("loop_status", status, 3'b010);
        pulse_clear();
        check("loop_clear", status[2:1], 2'b00);
        loop_en = 1'b0;

        for (int i = 0; i < 7; i++) begin
            if (vecs[i].clr_before) pulse_clear();
            send_frame(vecs[i].data, vecs[i].stop_bit, -10, -10);
            check($sformatf("vec%0d_rx_data", i), rx_data, vecs[i].exp_data);
            check($sformatf("vec%0d_status", i), status, vecs[i].exp_status);
        end

        // Three-cycle glitch is rejected, then a real frame still decodes
        pulse_clear();
        @(negedge clk);
        bench_rx = 1'b0;
        wait_neg(3);
        bench_rx = 1'b1;
        wait_neg(20);
        check("glitch_status", status, 3'b000);
        check("glitch_rx_data", rx_data, 8'h96);
        send_frame(8'h24, 1'b1, -10, -10);
        check("post_glitch_data", rx_data, 8'h24);
        check("post_glitch_status", status, 3'b010);

        // rx_enable dropped mid-frame aborts without effect
        pulse_clear();
        send_frame(8'h7E, 1'b1, -10, 30);
        check("abort_rx_data", rx_data, 8'h24);
        check("abort_status", status, 3'b000);
        cmd[1] = 1'b1;
        wait_neg(4);
        send_frame(8'h55, 1'b1, -10, -10);
        check("reenable_data", rx_data, 8'h55);
        check("reenable_status", status, 3'b010);

        // Clear coincident with stop sample: set wins; one cycle later: clear wins
        send_frame(8'h18, 1'b1, 78, -10);
        check("coinc_rx_data", rx_data, 8'h18);
        check("coinc_status", status, 3'b010);
        send_frame(8'h42, 1'b1, 79, -10);
        check("late_clr_data", rx_data, 8'h42);
        check("late_clr_status", status, 3'b000);

        // Reset mid-TX, then a start bit held high across reset release
        tx_data = 8'h00;
        cmd[0]  = 1'b1;
        @(negedge clk);
        cmd[0] = 1'b0;
        wait_neg(30);
        check("pre_reset_tx", uart_tx, 1'b0);
        reset_n = 1'b0;
        #1;
        check("midtx_reset_tx", uart_tx, 1'b1);
        check("midtx_reset_status", status, 3'b000);
        check("midtx_reset_rx_data", rx_data, 8'h00);
        cmd = 3'b011;
        wait_neg(2);
        reset_n = 1'b1;
        @(negedge clk);
        check("release_edge_busy", status[0], 1'b1);
        check("release_edge_tx", uart_tx, 1'b0);
        wait_neg(85);
        check("release_frame_done", status[0], 1'b0);
        check("release_frame_line", uart_tx, 1'b1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule

// File: doc/uart_cmd_engine.md
UART_CMD_ENGINE -- requirements
Module: uart_cmd_engine

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 434, clk cycles per UART bit (50 MHz / 115200); legal range 4..65535.
REQ-002 SHALL have port clk  input  1  system clock; all logic in this single domain.
REQ-003 SHALL have port reset_n  input  1  reset, asynchronous, active-low.
REQ-004 SHALL have port cmd_i  input  3  command word from PIO: [0] tx_start (rising-edge), [1] rx_enable (level), [2] clear_flags (rising-edge).
REQ-005 SHALL have port tx_data_i  input  8  byte to transmit, sampled on tx_start edge.
REQ-006 SHALL have port uart_rx_i  input  1  asynchronous serial input line.
REQ-007 SHALL have port status_o  output  3  status word to PIO: [0] tx_busy, [1] rx_valid, [2] rx_error.
REQ-008 SHALL have port rx_data_o  output  8  last correctly framed received byte.
REQ-009 SHALL have port uart_tx_o  output  1  serial output line, idle high.

Function
REQ-010 SHALL detect cmd_i[0] and cmd_i[2] rising edges by comparing each with a registered previous value.
REQ-011 SHALL pass uart_rx_i through a 2-flop synchronizer before any use.
REQ-012 SHALL format frames 8N1: one start bit (0), 8 data bits LSB first, one stop bit (1), each exactly CLKS_PER_BIT cycles.
REQ-013 TX FSM states: IDLE, START, DATA, STOP; IDLE->START on tx_start edge, START->DATA and DATA->STOP after bit time (DATA after 8 bits), STOP->IDLE after bit time.
REQ-014 On tx_start edge detected in cycle N while TX IDLE, SHALL latch tx_data_i in cycle N and drive uart_tx_o low and tx_busy high from cycle N+1.
REQ-015 tx_busy SHALL stay high through the final stop-bit cycle and fall in the cycle uart_tx_o's stop bit ends (TX back in IDLE); a full frame occupies 10*CLKS_PER_BIT cycles.
REQ-016 A tx_start edge while TX not IDLE SHALL be ignored (no queueing); tx_data_i changes during a frame SHALL not affect it.
REQ-017 RX FSM states: IDLE, START, DATA, STOP; RX SHALL leave IDLE only when rx_enable=1 and synchronized line is 0.
REQ-018 In START, RX SHALL resample at CLKS_PER_BIT/2 (integer floor); if line is 1, return to IDLE with no flag change (glitch reject).
REQ-019 Data and stop bits SHALL be sampled once each at bit centre, spaced CLKS_PER_BIT cycles from the start-bit centre sample.
REQ-020 Stop sample 1: rx_data_o updated and rx_valid set in same cycle; stop sample 0: rx_error set, rx_data_o unchanged, rx_valid unchanged.
REQ-021 A new good frame while rx_valid=1 SHALL overwrite rx_data_o; rx_valid stays 1 (no overrun flag).
REQ-022 clear_flags edge SHALL clear rx_valid and rx_error next cycle; if a set event occurs in the same cycle, the set wins.
REQ-023 rx_enable falling to 0 mid-frame SHALL abort RX to IDLE the next cycle without changing rx_data_o or flags; TX unaffected.
REQ-024 Bit counters SHALL be sized ceil(log2(CLKS_PER_BIT)) bits and reset to 0 on every state transition; no wrap inside a bit period.
REQ-025 TX and RX SHALL operate fully independently and concurrently (loopback of uart_tx_o to uart_rx_i legal).

Reset
REQ-026 On reset_n low, asynchronously: uart_tx_o=1, status_o=0, rx_data_o=0, both FSMs IDLE, counters 0, synchronizer flops 1, edge-detect registers 0.
REQ-027 A cmd bit already high at reset release SHALL be treated as a rising edge in the first clock after release.
REQ-028 Reset asserted mid-frame SHALL abort both FSMs immediately; uart_tx_o returns high with no partial stop bit.

Verification (CLKS_PER_BIT=8)
REQ-029 TX: tx_data_i=0xA5, pulse cmd_i[0] -> uart_tx_o sequence 0,1,0,1,0,0,1,0,1,1 each 8 cycles; tx_busy high 80 cycles.
REQ-030 Loopback, rx_enable=1, send 0x3C -> rx_data_o=0x3C, rx_valid=1, rx_error=0; clear_flags edge -> status_o[2:1]=00.
REQ-031 RX frame 0x81 with stop bit forced 0 -> rx_error=1, rx_data_o keeps prior value, rx_valid unchanged.
REQ-032 3-cycle low glitch on uart_rx_i -> RX back to IDLE, no flag change; second tx_start edge mid-frame -> ignored, frame intact.
REQ-033 Clear_flags edge coincident with stop-bit sample -> rx_valid=1 after; reset_n pulse mid-TX -> uart_tx_o=1, status_o=0 immediately.
